// File: rtl/envelope_sequencer.sv
// Note envelope sequencer: counts a note down on tick strobes and scales the
// incoming sample stream by the decay gain that the external lookup returns.
module envelope_sequencer #(
    parameter int SAMPLE_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       note_start,
    input  logic [5:0]                 duration,
    input  logic                       tick,
    output logic [5:0]                 curr,
    output logic [5:0]                 start,
    input  logic [7:0]                 multiple,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_out_valid,
    output logic                       active,
    output logic                       done
);

    localparam int PW = SAMPLE_W + 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [5:0]        curr_next;
    logic [5:0]        start_next;
    logic [7:0]        gain;
    logic signed [PW-1:0] sample_ext;
    logic signed [PW-1:0] gain_ext;
    logic signed [PW-1:0] product;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        curr_next  = curr;
        start_next = start;
        if (note_start) begin
            start_next = duration;
            curr_next  = duration;
            state_next = ST_PLAY;
        end else begin
            case (state)
                ST_PLAY: begin
                    if (tick) begin
                        if (curr != 6'd0) curr_next  = curr - 6'd1;
                        else              state_next = ST_DONE;
                    end
                end
                ST_DONE: state_next = ST_IDLE;
                default: state_next = state;
            endcase
        end
    end

    // Silent while idle; the lookup's gain applies through the done cycle.
    assign gain       = (state == ST_IDLE) ? 8'd0 : multiple;
    assign sample_ext = {{9{sample_in[SAMPLE_W-1]}}, sample_in};
    assign gain_ext   = {{(PW-8){1'b0}}, gain};
    assign product    = sample_ext * gain_ext;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= ST_IDLE;
            curr             <= '0;
            start            <= '0;
            active           <= 1'b0;
            done             <= 1'b0;
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
        end else begin
            state            <= state_next;
            curr             <= curr_next;
            start            <= start_next;
            active           <= (state_next == ST_PLAY);
            done             <= (state_next == ST_DONE);
            sample_out_valid <= sample_valid;
            // Arithmetic shift floors toward minus infinity; g <= 1.0 keeps it in range.
            if (sample_valid) sample_out <= SAMPLE_W'(product >>> 7);
        end
    end

endmodule

// File: tb/tb_envelope_sequencer.sv
// Randomised scoreboard bench for envelope_sequencer: a note-level reference
// model predicts status per cycle and each enveloped sample.
module tb_envelope_sequencer;

    logic               clk = 1'b0;
    logic               rst;
    logic               note_start;
    logic [5:0]         duration;
    logic               tick;
    logic [5:0]         curr;
    logic [5:0]         start;
    logic [7:0]         multiple;
    logic signed [15:0] sample_in;
    logic               sample_valid;
    logic signed [15:0] sample_out;
    logic               sample_out_valid;
    logic               active;
    logic               done;

    always #5 clk = ~clk;

    envelope_sequencer #(.SAMPLE_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .note_start       (note_start),
        .duration         (duration),
        .tick             (tick),
        .curr             (curr),
        .start            (start),
        .multiple         (multiple),
        .sample_in        (sample_in),
        .sample_valid     (sample_valid),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .active           (active),
        .done             (done)
    );

    typedef struct {
        longint curr;
        longint start;
        longint active;
        longint done;
        longint out_valid;
        longint hold;
    } status_t;

    status_t status_q[$];
    longint  sample_q[$];
    int      checks = 0;
    int      errors = 0;

    // Note-level model: a note lasts duration+1 ticks, then one done cycle.
    bit      m_sounding = 1'b0;
    bit      m_ending   = 1'b0;
    longint  m_start    = 0;
    longint  m_ticks    = 0;
    longint  m_hold     = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint scaled(input longint s, input longint g);
        longint p;
        longint q;
        p = s * g;
        q = p / 128;
        if (p < 0 && (p % 128) != 0) q = q - 1;
        return q;
    endfunction

    task automatic cyc(input bit r, input bit n, input int d, input bit t,
                       input bit v, input int s, input int m);
        longint  g;
        status_t st;
        @(negedge clk);
        rst          = r;
        note_start   = n;
        duration     = d[5:0];
        tick         = t;
        sample_valid = v;
        sample_in    = s[15:0];
        multiple     = m[7:0];
        g = (m_sounding || m_ending) ? longint'(m) : 0;
        if (!r) begin
            m_sounding = 1'b0;
            m_ending   = 1'b0;
            m_start    = 0;
            m_ticks    = 0;
            m_hold     = 0;
        end else begin
            if (v) begin
                m_hold = scaled(longint'(sample_in), g);
                sample_q.push_back(m_hold);
            end
            if (n) begin
                m_start    = longint'(d);
                m_ticks    = 0;
                m_sounding = 1'b1;
                m_ending   = 1'b0;
            end else if (m_ending) begin
                m_ending = 1'b0;
            end else if (m_sounding && t) begin
                if (m_ticks == m_start) begin
                    m_sounding = 1'b0;
                    m_ending   = 1'b1;
                end else begin
                    m_ticks = m_ticks + 1;
                end
            end
        end
        st.curr      = m_start - m_ticks;
        st.start     = m_start;
        st.active    = longint'(m_sounding);
        st.done      = longint'(m_ending);
        st.out_valid = longint'(r && v);
        st.hold      = m_hold;
        status_q.push_back(st);
        @(posedge clk);
    endtask

    // Monitor: compares status every cycle, pops a sample whenever the DUT presents one.
    initial begin
        status_t st;
        forever begin
            @(posedge clk);
            #1;
            if (status_q.size() > 0) begin
                st = status_q.pop_front();
                check("curr", curr, st.curr);
                check("start", start, st.start);
                check("active", active, st.active);
                check("done", done, st.done);
                check("sample_out_valid", sample_out_valid, st.out_valid);
                if (sample_out_valid === 1'b1) begin
                    if (sample_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sample_unexpected: got %0d expected none at %0t",
                                 sample_out, $time);
                    end else begin
                        check("sample_out", sample_out, sample_q.pop_front());
                    end
                end else begin
                    check("sample_hold", sample_out, st.hold);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; note_start = 1'b0; duration = '0; tick = 1'b0;
        sample_valid = 1'b0; sample_in = '0; multiple = '0;

        // Reset overriding start, tick and a valid sample.
        cyc(0, 1, 7, 1, 1, 1234, 128);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // Idle mute.
        cyc(1, 0, 0, 0, 1, 5000, 100);
        cyc(1, 0, 0, 0, 0, 0, 100);
        // Countdown with gain and extreme samples while playing.
        cyc(1, 1, 3, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 1000, 128);
        cyc(1, 0, 0, 0, 1, -2000, 64);
        cyc(1, 0, 0, 0, 1, -32768, 128);
        cyc(1, 0, 0, 0, 1, 32767, 34);
        cyc(1, 0, 0, 0, 0, 0, 34);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 1, 300 * (i + 1), 90 - 10 * i);
        cyc(1, 0, 0, 1, 1, 777, 50);
        cyc(1, 0, 0, 0, 0, 0, 0);
        // Retrigger at curr=2 with a simultaneous tick.
        cyc(1, 1, 4, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        cyc(1, 1, 10, 1, 1, -4321, 100);
        cyc(1, 0, 0, 0, 0, 0, 0);
        // Reset mid-note at curr=5.
        cyc(1, 1, 8, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 9, 1, 1, 2222, 128);
        cyc(1, 0, 0, 0, 1, 3333, 128);
        // Zero-length note, then a retrigger landing on the done cycle.
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 1, -100, 128);
        cyc(1, 0, 0, 0, 1, -100, 77);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        cyc(1, 1, 2, 0, 1, 500, 120);
        cyc(1, 0, 0, 1, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(199, 0) != 0),
                ($urandom_range(19, 0) == 0),
                int'($urandom_range(15, 0)),
                ($urandom_range(9, 0) < 3),
                ($urandom_range(9, 0) < 6),
                int'($urandom),
                int'($urandom_range(128, 0)));
        end
        cyc(1, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        check("sample_q_drained", sample_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/envelope_sequencer.md
ENVELOPE_SEQUENCER -- requirements
Module: envelope_sequencer

Interface
REQ-001 Parameter: SAMPLE_W, default 16, signed audio sample width.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 note_start  input  1  single-cycle pulse; begin or retrigger a note.
REQ-005 duration  input  6  envelope length in ticks; sampled only when note_start=1.
REQ-006 tick  input  1  single-cycle envelope step strobe.
REQ-007 curr  output  6  remaining ticks; drives the decay lookup, which computes start-curr.
REQ-008 start  output  6  latched duration; drives the decay lookup.
REQ-009 multiple  input  8  unsigned gain from the lookup, Q1.7 (128 = 1.0); combinational function of curr/start.
REQ-010 sample_in  input  SAMPLE_W  signed sample, qualified by sample_valid.
REQ-011 sample_valid  input  1  sample_in valid this cycle.
REQ-012 sample_out  output  SAMPLE_W  signed enveloped sample.
REQ-013 sample_out_valid  output  1  sample_out valid this cycle.
REQ-014 active  output  1  high while a note is sounding (state PLAY).
REQ-015 done  output  1  single-cycle pulse at note end.

Function
REQ-016 FSM states IDLE, PLAY, DONE; all outputs registered.
REQ-017 IDLE: note_start -> start<=duration, curr<=duration, state PLAY.
REQ-018 PLAY: tick with curr>0 -> curr<=curr-1; tick with curr==0 -> state DONE; no tick -> hold.
REQ-019 PLAY with duration 0: the first tick moves to DONE (one tick of full gain).
REQ-020 DONE: done=1 for exactly one cycle; next state IDLE; curr, start hold their values.
REQ-021 IDLE: curr, start hold their last values; active=0.
REQ-022 note_start in any state (PLAY, DONE included) restarts per REQ-017; note_start wins over a simultaneous tick; no done pulse for a retriggered note.
REQ-023 Lookup index start-curr is 6-bit modulo; curr never exceeds start, so no wrap occurs in normal use.
REQ-024 Effective gain g = multiple in PLAY and DONE, 0 in IDLE.
REQ-025 Product = sample_in * {1'b0,g}, signed, SAMPLE_W+9 bits; sample_out = product arithmetic-shifted right by 7, truncated toward minus infinity, low SAMPLE_W bits.
REQ-026 No saturation: g<=128 guarantees the result fits.
REQ-027 Latency: 1 cycle; sample_out_valid(n+1) = sample_valid(n), computed with the gain from cycle n.
REQ-028 sample_out holds its value when sample_valid=0.
REQ-029 Gain changes on tick take effect for samples accepted on the cycle after curr updates.

Reset
REQ-030 rst=0 at a clock edge -> state IDLE, curr=0, start=0, sample_out=0, sample_out_valid=0, active=0, done=0.
REQ-031 Reset overrides note_start, tick and sample_valid in the same cycle; reset mid-PLAY aborts the note with no done pulse.

Verification
REQ-032 Countdown: duration=3, note_start, then 4 ticks -> curr 3,2,1,0; DONE on the 4th tick; done pulses once; active falls.
REQ-033 Gain: PLAY, multiple=128, sample_in=1000 -> sample_out=1000 one cycle later; multiple=64, sample_in=-2000 -> -1000.
REQ-034 Extremes: multiple=128, sample_in=-32768 -> -32768; multiple=34, sample_in=32767 -> 8703.
REQ-035 IDLE mute: sample_valid=1, sample_in=5000 -> sample_out=0, sample_out_valid=1.
REQ-036 Retrigger: curr=2 in PLAY; note_start with duration=10 plus simultaneous tick -> curr=10, start=10, no done.
REQ-037 Reset mid-note: rst=0 while curr=5 -> next cycle all outputs 0, state IDLE.
